divider_arbiter: RTL and testbench
==================================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter WIDTH_A, default 8, dividend and quotient width.
REQ-002 Parameter WIDTH_B, default 4, divisor and remainder width.
REQ-003 Parameter N_REQ, default 4, number of requesters (2..16).
REQ-004 Parameter TIMEOUT, default 64, watchdog limit in cycles (used only with DIV_ARB_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  N_REQ  per-requester operation request.
REQ-008 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-009 req_a  in  N_REQ*WIDTH_A  packed dividends; requester i at slice i.
REQ-010 req_b  in  N_REQ*WIDTH_B  packed divisors.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  result consumer accept.
REQ-013 rsp_id  out  IDW  owning requester index; IDW = max(1, clog2(N_REQ)).
REQ-014 rsp_q  out  WIDTH_A  quotient.
REQ-015 rsp_r  out  WIDTH_B  remainder.
REQ-016 rsp_err  out  1  divide-by-zero (or timeout when enabled).
REQ-017 div_a / div_b  out  WIDTH_A / WIDTH_B  operands to the shared general_divider.
REQ-018 div_start  out  1  one-cycle launch pulse to the divider.
REQ-019 div_q / div_r / div_done  in  WIDTH_A / WIDTH_B / 1  divider results; div_done one-cycle pulse.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states IDLE, LAUNCH, WAIT, RESP; IDLE->LAUNCH on any req_valid, LAUNCH->WAIT unconditionally, WAIT->RESP on div_done, RESP->IDLE on rsp_valid&&rsp_ready.
REQ-022 Grant in IDLE: round-robin, search starts at (last_grant+1) mod N_REQ; after reset, search starts at index 0.
REQ-023 req_ready[g] asserted combinationally for exactly the IDLE cycle the grant is taken; operands captured that edge.
REQ-024 LAUNCH: div_a/div_b driven from captured operands, div_start=1 for exactly one cycle; div_a/div_b held stable through WAIT.
REQ-025 Divisor zero: skip LAUNCH/WAIT, go IDLE->RESP directly, rsp_q=all ones, rsp_r=0, rsp_err=1, no div_start.
REQ-026 RESP: rsp_q/rsp_r registered from div_q/div_r at div_done edge; rsp_id=grant; outputs stable while rsp_valid&&!rsp_ready.
REQ-027 Latency accept-to-rsp_valid = divider latency + 2 cycles; divide-by-zero = 1 cycle.
REQ-028 div_done outside WAIT is ignored.
REQ-029 No new grant while a response is pending; requesters hold req_valid and operands until req_ready.
REQ-030 req_valid deasserting without grant is legal; no state is kept for it.

Reset
REQ-031 On rst_n low, immediately: state=IDLE, last_grant=N_REQ-1, rsp_valid=0, rsp_q=0, rsp_r=0, rsp_id=0, rsp_err=0, div_start=0, div_a=0, div_b=0, req_ready=0, busy=0.
REQ-032 Reset mid-operation abandons the operation; a later div_done is ignored by REQ-028.

Configuration
REQ-033 Macro DIV_ARB_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT cycles without div_done go to RESP with rsp_q=0, rsp_r=0, rsp_err=1.
REQ-034 Macro undefined: no counter; WAIT waits indefinitely for div_done.

Structure
REQ-035 Package div_pkg holds the state enum (IDLE, LAUNCH, WAIT, RESP) and the default width constants shared with general_divider.
REQ-036 Sub-module rr_arbiter (N_REQ request vector, enable, one-hot grant, last-grant pointer) is instantiated once; everything else in divider_arbiter.

Verification
REQ-037 Single request: req 0, A=0x8C, B=9 -> one div_start pulse, rsp_id=0, rsp_q=0x0F, rsp_r=5, rsp_err=0.
REQ-038 All four valid continuously after reset, rsp_ready=1 -> grants in order 0,1,2,3,0.
REQ-039 Req 2 with B=0, A=0x55 -> no div_start, next cycle rsp_valid, rsp_q=0xFF, rsp_r=0, rsp_err=1.
REQ-040 rsp_ready held low 5 cycles in RESP -> outputs unchanged, no req_ready, grant resumes after accept.
REQ-041 rst_n pulsed low during WAIT, then div_done -> all outputs at reset values, no rsp_valid.
REQ-042 With DIV_ARB_TIMEOUT_EN and div_done suppressed -> rsp_valid exactly TIMEOUT cycles after entering WAIT, rsp_err=1.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
// Shared state encoding and default operand widths for the divider arbiter
// and the general_divider it fronts.
package div_pkg;

  localparam int DIV_WIDTH_A = 8;
  localparam int DIV_WIDTH_B = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted index.
// The pointer only moves when a grant is actually taken (en_i high).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   gnt_idx_o,
  output logic             any_o
);

  logic [IDW-1:0] last_q, last_d;
  logic           found;
  int             k;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = int'(last_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (en_i && !found && req_i[IDW'(k)]) begin
        found            = 1'b1;
        gnt_o[IDW'(k)]   = 1'b1;
        gnt_idx_o        = IDW'(k);
      end
    end
  end

  assign any_o  = found;
  assign last_d = found ? gnt_idx_o : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDW'(N_REQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one general_divider among N_REQ requesters (round-robin).
// Optional WAIT watchdog is built when DIV_ARB_TIMEOUT_EN is defined.
module divider_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH_A = DIV_WIDTH_A,
  parameter int WIDTH_B = DIV_WIDTH_B,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*WIDTH_A-1:0]    req_a,
  input  logic [N_REQ*WIDTH_B-1:0]    req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(N_REQ)-1:0]  rsp_id,
  output logic [WIDTH_A-1:0]          rsp_q,
  output logic [WIDTH_B-1:0]          rsp_r,
  output logic                        rsp_err,
  output logic [WIDTH_A-1:0]          div_a,
  output logic [WIDTH_B-1:0]          div_b,
  output logic                        div_start,
  input  logic [WIDTH_A-1:0]          div_q,
  input  logic [WIDTH_B-1:0]          div_r,
  input  logic                        div_done,
  output logic                        busy
);

  localparam int IDW = id_width(N_REQ);

  state_e state_q, state_d;

  logic [N_REQ-1:0]   gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               take;
  logic               zero_div;
  logic               tmo;

  logic [WIDTH_A-1:0] a_arr [N_REQ];
  logic [WIDTH_B-1:0] b_arr [N_REQ];
  logic [WIDTH_A-1:0] sel_a;
  logic [WIDTH_B-1:0] sel_b;

  logic [WIDTH_A-1:0] a_q, a_d;
  logic [WIDTH_B-1:0] b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH_A-1:0] quot_q, quot_d;
  logic [WIDTH_B-1:0] rem_q, rem_d;
  logic               err_q, err_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH_A +: WIDTH_A];
    assign b_arr[i] = req_b[i*WIDTH_B +: WIDTH_B];
  end

  // Grants only in IDLE, and never while reset is asserted.
  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (rst_n && (state_q == IDLE)),
    .req_i     (req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (take)
  );

  assign sel_a    = a_arr[gnt_idx];
  assign sel_b    = b_arr[gnt_idx];
  assign zero_div = (sel_b == '0);

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo   = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = zero_div ? RESP : LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (div_done || tmo) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    id_d   = id_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    err_d  = err_q;
    if (take) begin
      a_d  = sel_a;
      b_d  = sel_b;
      id_d = gnt_idx;
      if (zero_div) begin
        quot_d = '1;
        rem_d  = '0;
        err_d  = 1'b1;
      end
    end
    if (state_q == WAIT) begin
      if (div_done) begin
        quot_d = div_q;
        rem_d  = div_r;
        err_d  = 1'b0;
      end else if (tmo) begin
        quot_d = '0;
        rem_d  = '0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = gnt;
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign div_start = (state_q == LAUNCH);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_q     = quot_q;
  assign rsp_r     = rem_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus randomized traffic
// against a one-outstanding-operation reference model and divider model.
module tb_divider_arbiter;

  localparam int WA  = 8;
  localparam int WB  = 4;
  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [WA-1:0]   rsp_q;
  logic [WB-1:0]   rsp_r;
  logic            rsp_err;
  logic [WA-1:0]   div_a;
  logic [WB-1:0]   div_b;
  logic            div_start;
  logic [WA-1:0]   div_q;
  logic [WB-1:0]   div_r;
  logic            div_done;
  logic            busy;

  always #5 clk = ~clk;

  divider_arbiter #(
    .WIDTH_A (WA),
    .WIDTH_B (WB),
    .N_REQ   (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_err   (rsp_err),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_start (div_start),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_done  (div_done),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  // requester side
  bit          want [N];
  logic [WA-1:0] opa [N];
  logic [WB-1:0] opb [N];
  bit          refill  = 0;
  bit          autogen = 0;
  int          rmode   = 0;

  // reference model
  int          cyc     = 0;
  bit          outst   = 0;
  int          last_g  = N - 1;
  int          acc_cyc = 0;
  int          acc_id  = 0;
  logic [WA-1:0] e_a   = '0;
  logic [WB-1:0] e_b   = '0;
  bit          e_tmo   = 0;
  int          exp_lat = 1;
  bit          seen_rv = 0;
  int          lat_obs = 0;
  int          gq[$];

  // divider model
  int          dcnt      = 0;
  int          lat_cur   = 1;
  int          lat_force = 0;
  bit          suppress  = 0;
  bit          noise     = 0;
  logic [WA-1:0] dq = '0;
  logic [WB-1:0] dr = '0;
  int          done_cnt = 0;
  int          nstart   = 0;

  // last accepted response as seen on the port
  logic [31:0] last_id, last_q, last_r, last_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = want[i];
      req_a[i*WA +: WA]     = opa[i];
      req_b[i*WB +: WB]     = opb[i];
    end
  endtask

  task automatic set_op(input int i, input logic [WA-1:0] a,
                        input logic [WB-1:0] b);
    want[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  task automatic newop(input int i);
    logic [WB-1:0] b;
    b = ($urandom_range(0, 5) == 0) ? '0 : WB'($urandom);
    set_op(i, WA'($urandom), b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_rsp_r", rsp_r, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    #1;
    rst_n   = 1'b1;
    outst   = 0;
    last_g  = N - 1;
    seen_rv = 0;
  endtask

  task automatic cycle();
    int g, idx, rel;
    bit exp_rv, exp_st;
    logic [N-1:0] exp_rdy;
    logic [31:0] eq, er, ee;
    @(negedge clk);
    cyc++;
    g = -1;
    if (!outst) begin
      for (int k = 1; k <= N; k++) begin
        idx = (last_g + k) % N;
        if (g < 0 && want[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rel    = cyc - acc_cyc;
    exp_rv = outst && (rel >= exp_lat);
    exp_st = outst && (e_b != 0) && (rel == 1);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, outst);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("div_start", div_start, exp_st);
    if (outst && e_b != 0 && rel >= 1 && rel < exp_lat) begin
      chk("div_a", div_a, e_a);
      chk("div_b", div_b, e_b);
    end
    if (exp_rv) begin
      if (e_b == 0) begin
        eq = 32'hFF; er = 0; ee = 1;
      end else if (e_tmo) begin
        eq = 0; er = 0; ee = 1;
      end else begin
        eq = int'(e_a) / int'(e_b);
        er = int'(e_a) % int'(e_b);
        ee = 0;
      end
      chk("rsp_id", rsp_id, acc_id);
      chk("rsp_q", rsp_q, eq);
      chk("rsp_r", rsp_r, er);
      chk("rsp_err", rsp_err, ee);
    end
    if (outst && rsp_valid && !seen_rv) begin
      seen_rv = 1;
      lat_obs = rel;
    end
    if (div_start) begin
      nstart++;
      dcnt = lat_cur;
      if (div_b != 0) begin
        dq = div_a / WA'(div_b);
        dr = WB'(div_a % WA'(div_b));
      end
    end
    if (exp_rv && rsp_ready) begin
      outst    = 0;
      last_id  = rsp_id;
      last_q   = rsp_q;
      last_r   = rsp_r;
      last_err = rsp_err;
    end
    if (g >= 0) begin
      outst   = 1;
      acc_cyc = cyc;
      acc_id  = g;
      e_a     = opa[g];
      e_b     = opb[g];
      e_tmo   = suppress;
      last_g  = g;
      seen_rv = 0;
      lat_cur = (lat_force > 0) ? lat_force : $urandom_range(1, 6);
      exp_lat = (e_b == 0) ? 1 : (suppress ? TMO + 2 : lat_cur + 2);
      gq.push_back(g);
    end
    @(posedge clk);
    #1;
    div_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && !suppress) begin
        div_done = 1'b1;
        div_q    = dq;
        div_r    = dr;
        done_cnt++;
      end
    end else if (noise && !outst && $urandom_range(0, 7) == 0) begin
      div_done = 1'b1;
      div_q    = WA'($urandom);
      div_r    = WB'($urandom);
    end
    if (g >= 0) begin
      want[g] = 0;
      if (refill) newop(g);
    end
    if (autogen) begin
      for (int i = 0; i < N; i++)
        if (!want[i] && $urandom_range(0, 3) == 0) newop(i);
    end
    case (rmode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
    drive();
  endtask

  initial begin
    int d0;
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      opa[i]  = '0;
      opb[i]  = '0;
    end
    rsp_ready = 1'b1;
    div_q     = '0;
    div_r     = '0;
    div_done  = 1'b0;
    drive();
    #1;
    do_reset();
    cycle();

    // single request
    nstart    = 0;
    lat_force = 4;
    set_op(0, 8'h8C, 4'd9);
    drive();
    repeat (12) cycle();
    chk("t037_starts", nstart, 1);
    chk("t037_id", last_id, 0);
    chk("t037_q", last_q, 32'h0F);
    chk("t037_r", last_r, 5);
    chk("t037_err", last_err, 0);
    chk("t037_lat", lat_obs, 6);
    lat_force = 0;

    // divide by zero
    nstart = 0;
    set_op(2, 8'h55, 4'd0);
    drive();
    repeat (4) cycle();
    chk("t039_starts", nstart, 0);
    chk("t039_id", last_id, 2);
    chk("t039_q", last_q, 32'hFF);
    chk("t039_r", last_r, 0);
    chk("t039_err", last_err, 1);
    chk("t039_lat", lat_obs, 1);

    // all four requesting continuously from reset
    do_reset();
    gq.delete();
    for (int i = 0; i < N; i++) newop(i);
    drive();
    refill = 1;
    repeat (40) cycle();
    refill = 0;
    repeat (80) cycle();
    chk("t038_count", gq.size() >= 5, 1);
    if (gq.size() >= 5) begin
      chk("t038_g0", gq[0], 0);
      chk("t038_g1", gq[1], 1);
      chk("t038_g2", gq[2], 2);
      chk("t038_g3", gq[3], 3);
      chk("t038_g4", gq[4], 0);
    end

    // back-pressure in RESP
    rmode = 2;
    set_op(1, 8'hA7, 4'd5);
    drive();
    for (int i = 0; i < 20 && !(outst && seen_rv); i++) cycle();
    set_op(3, 8'h40, 4'd3);
    drive();
    repeat (5) cycle();
    rmode = 0;
    repeat (20) cycle();
    chk("t040_next_grant", gq[gq.size()-1], 3);
    chk("t040_id", last_id, 3);
    chk("t040_q", last_q, 32'h15);
    chk("t040_r", last_r, 1);

    // reset while waiting on the divider
    lat_force = 5;
    set_op(0, 8'hC8, 4'd7);
    drive();
    for (int i = 0; i < 12 && !(outst && (cyc - acc_cyc) == 2); i++) cycle();
    do_reset();
    d0 = done_cnt;
    repeat (10) cycle();
    chk("t041_late_done", done_cnt - d0, 1);
    lat_force = 0;

`ifdef DIV_ARB_TIMEOUT_EN
    suppress = 1;
    set_op(1, 8'h33, 4'd2);
    drive();
    repeat (TMO + 8) cycle();
    suppress = 0;
    chk("t042_lat", lat_obs, TMO + 2);
    chk("t042_err", last_err, 1);
    chk("t042_q", last_q, 0);
`endif

    // randomized traffic
    autogen = 1;
    noise   = 1;
    rmode   = 1;
    repeat (3000) cycle();
    autogen = 0;
    rmode   = 0;
    repeat (100) cycle();
    chk("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
